// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-wide RAM controller: FSM state encoding
// and the number of states.
package mem_ctrl_pkg;

  localparam int STATE_COUNT = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_LO  = 3'd1,
    WR_HI  = 3'd2,
    RD_LO  = 3'd3,
    RD_MID = 3'd4,
    RD_CAP = 3'd5,
    RESP   = 3'd6
  } state_t;

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: bridges 8/16-bit core requests onto an 8-bit synchronous RAM
// with a one-cycle registered read. Word accesses are little-endian (A, A+1).
// Optional feature: define MEM_CTRL_WRAP_FAULT_EN to reject word accesses at
// A=16'hFFFF with rsp_fault instead of wrapping the high byte to 16'h0000.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_word,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic        mem_oe,
  inout  wire  [7:0]  mem_data
);

  state_t      state_r;
  state_t      state_next_s;
  logic [15:0] addr_r;
  logic [15:0] wdata_r;
  logic        word_r;
  logic [7:0]  lo_r;
  logic [15:0] rdata_r;
  logic [15:0] mem_addr_r;
  logic        we_r;
  logic        oe_r;
  logic [15:0] addr_next_s;
  logic        we_next_s;
  logic        oe_next_s;
  logic        accept_s;
  logic        wrap_fault_s;
  logic [15:0] addr_inc_s;
  logic [7:0]  dout_s;

  assign accept_s   = req_valid & (state_r == IDLE);
  assign addr_inc_s = addr_r + 16'd1;

`ifdef MEM_CTRL_WRAP_FAULT_EN
  logic fault_r;

  assign wrap_fault_s = req_word & (req_addr == 16'hFFFF);

  // Fault flag latched at acceptance, presented with the RESP pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_r <= 1'b0;
    end else if (accept_s) begin
      fault_r <= wrap_fault_s;
    end
  end

  assign rsp_fault = fault_r;
`else
  assign wrap_fault_s = 1'b0;
  assign rsp_fault    = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state plus the bus controls for the next state, so the RAM pins are register-driven.
  always_comb begin
    state_next_s = state_r;
    addr_next_s  = mem_addr_r;
    we_next_s    = 1'b0;
    oe_next_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          if (wrap_fault_s) begin
            state_next_s = RESP;
          end else if (req_write) begin
            state_next_s = WR_LO;
            addr_next_s  = req_addr;
            we_next_s    = 1'b1;
          end else begin
            state_next_s = RD_LO;
            addr_next_s  = req_addr;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WR_LO: begin
        if (word_r) begin
          state_next_s = WR_HI;
          addr_next_s  = addr_inc_s;
          we_next_s    = 1'b1;
        end else begin
          state_next_s = RESP;
        end
      end
      WR_HI:  state_next_s = RESP;
      RD_LO: begin
        oe_next_s = 1'b1;
        if (word_r) begin
          state_next_s = RD_MID;
          addr_next_s  = addr_inc_s;
        end else begin
          state_next_s = RD_CAP;
          addr_next_s  = addr_r;
        end
      end
      RD_MID: begin
        state_next_s = RD_CAP;
        addr_next_s  = addr_inc_s;
        oe_next_s    = 1'b1;
      end
      RD_CAP: state_next_s = RESP;
      RESP:   state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Request capture, RAM pin registers and read-data assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r     <= 16'h0000;
      wdata_r    <= 16'h0000;
      word_r     <= 1'b0;
      lo_r       <= 8'h00;
      rdata_r    <= 16'h0000;
      mem_addr_r <= 16'h0000;
      we_r       <= 1'b0;
      oe_r       <= 1'b0;
    end else begin
      mem_addr_r <= addr_next_s;
      we_r       <= we_next_s;
      oe_r       <= oe_next_s;
      if (accept_s) begin
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
        word_r  <= req_word;
        rdata_r <= 16'h0000;
      end else if (state_r == RD_MID) begin
        lo_r <= mem_data;
      end else if (state_r == RD_CAP) begin
        rdata_r <= word_r ? {mem_data, lo_r} : {8'h00, mem_data};
      end
    end
  end

  assign req_ready = (state_r == IDLE);
  assign rsp_valid = (state_r == RESP);
  assign rsp_rdata = rdata_r;
  assign mem_addr  = mem_addr_r;
  // Reset kills the strobes immediately so an interrupted write never lands.
  assign mem_we    = we_r & ~rst;
  assign mem_oe    = oe_r & ~rst;
  assign dout_s    = (state_r == WR_HI) ? wdata_r[15:8] : wdata_r[7:0];
  assign mem_data  = mem_we ? dout_s : 8'hzz;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: synchronous RAM model, directed vector
// table, multi-cycle corner sequences and a randomized run against a
// byte-array reference model.
module tb_mem_ctrl;

`ifdef MEM_CTRL_WRAP_FAULT_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_word = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic [15:0] req_wdata = 16'h0000;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_fault;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic        mem_oe;
  wire  [7:0]  mem_data;

  mem_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_word(req_word), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_oe(mem_oe), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  // RAM model: registered read, write sampled on the rising edge.
  logic [7:0] ram [0:65535];
  logic [7:0] rd_q = 8'h00;
  logic       ram_init = 1'b0;

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5C;
  endfunction

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 65536; i++) ram[i] <= init_byte(16'(i));
    end else begin
      if (mem_we) ram[mem_addr] <= mem_data;
      rd_q <= ram[mem_addr];
    end
  end
  assign mem_data = mem_oe ? rd_q : 8'hzz;

  // Bus monitor.
  int         we_cnt = 0;
  int         overlap_cnt = 0;
  logic [15:0] last_we_addr = 16'h0000;
  logic [7:0]  last_we_data = 8'h00;
  always @(posedge clk) begin
    if (mem_we) begin
      we_cnt = we_cnt + 1;
      last_we_addr = mem_addr;
      last_we_data = mem_data;
    end
    if (mem_we && mem_oe) overlap_cnt = overlap_cnt + 1;
  end

  // Reference model: byte array plus the timing rules of the controller.
  logic [7:0] ref_mem [0:65535];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit is_fault(input logic wd, input logic [15:0] a);
    return WRAP_EN && wd && (a == 16'hFFFF);
  endfunction

  function automatic int exp_lat(input logic wr, input logic wd, input logic [15:0] a);
    if (is_fault(wd, a)) return 1;
    if (wr) return wd ? 3 : 2;
    return wd ? 4 : 3;
  endfunction

  // Applies one access to the reference and returns the expected read data.
  function automatic logic [15:0] model_access(input logic wr, input logic wd,
                                               input logic [15:0] a, input logic [15:0] wdt);
    logic [15:0] a1;
    a1 = a + 16'd1;
    if (is_fault(wd, a)) return 16'h0000;
    if (wr) begin
      ref_mem[a] = wdt[7:0];
      if (wd) ref_mem[a1] = wdt[15:8];
      return 16'h0000;
    end
    return wd ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
  endfunction

  task automatic do_req(input logic wr, input logic wd, input logic [15:0] a,
                        input logic [15:0] wdt, output int lat,
                        output logic [15:0] rd, output logic flt);
    int w;
    lat = 0; rd = 16'h0000; flt = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_word = wd; req_addr = a; req_wdata = wdt;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      if (rsp_valid) begin
        lat = k; rd = rsp_rdata; flt = rsp_fault;
        break;
      end
    end
  endtask

  typedef struct {
    logic        wr;
    logic        wd;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
    logic [15:0] rdata;
  } vec_t;

  vec_t vt [6];

  initial begin
    int          lat;
    logic [15:0] rd;
    logic        flt;
    int          we0;
    logic [7:0]  keep;
    logic [15:0] hq [3];
    int          acc_cyc [3];
    int          idx;
    int          pulses;

    vt[0] = '{1'b1, 1'b0, 16'h1234, 16'h00AB, 2, 16'h0000};
    vt[1] = '{1'b0, 1'b0, 16'h1234, 16'h0000, 3, 16'h00AB};
    vt[2] = '{1'b1, 1'b1, 16'h2000, 16'hBEEF, 3, 16'h0000};
    vt[3] = '{1'b0, 1'b1, 16'h2000, 16'h0000, 4, 16'hBEEF};
    vt[4] = '{1'b0, 1'b0, 16'h2001, 16'h0000, 3, 16'h00BE};
    vt[5] = '{1'b0, 1'b0, 16'h2000, 16'h0000, 3, 16'h00EF};

    for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(16'(i));

    // Reset and RAM preload.
    rst = 1'b1;
    ram_init = 1'b1;
    @(negedge clk);
    ram_init = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rdata", {16'd0, rsp_rdata}, 32'd0);
    chk("reset_fault", {31'd0, rsp_fault}, 32'd0);
    chk("reset_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("reset_we", {31'd0, mem_we}, 32'd0);
    chk("reset_oe", {31'd0, mem_oe}, 32'd0);

    // Directed vector table.
    for (int i = 0; i < 6; i++) begin
      we0 = we_cnt;
      do_req(vt[i].wr, vt[i].wd, vt[i].addr, vt[i].wdata, lat, rd, flt);
      void'(model_access(vt[i].wr, vt[i].wd, vt[i].addr, vt[i].wdata));
      chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("vec%0d_fault", i), {31'd0, flt}, 32'd0);
      if (!vt[i].wr) chk($sformatf("vec%0d_rdata", i), {16'd0, rd}, {16'd0, vt[i].rdata});
      else chk($sformatf("vec%0d_we_pulses", i), we_cnt - we0, vt[i].wd ? 2 : 1);
      if (i == 0) begin
        chk("bytewr_we_addr", {16'd0, last_we_addr}, 32'h1234);
        chk("bytewr_we_data", {24'd0, last_we_data}, 32'hAB);
      end
    end
    chk("ram_2000", {24'd0, ram[16'h2000]}, 32'hEF);
    chk("ram_2001", {24'd0, ram[16'h2001]}, 32'hBE);

    // Boundary: word write at 16'hFFFF.
    we0 = we_cnt;
    do_req(1'b1, 1'b1, 16'hFFFF, 16'h55AA, lat, rd, flt);
    void'(model_access(1'b1, 1'b1, 16'hFFFF, 16'h55AA));
    chk("wrap_latency", lat, WRAP_EN ? 1 : 3);
    chk("wrap_fault", {31'd0, flt}, {31'd0, WRAP_EN});
    chk("wrap_we_pulses", we_cnt - we0, WRAP_EN ? 0 : 2);
    chk("wrap_ram_ffff", {24'd0, ram[16'hFFFF]}, WRAP_EN ? {24'd0, init_byte(16'hFFFF)} : 32'hAA);
    chk("wrap_ram_0000", {24'd0, ram[16'h0000]}, WRAP_EN ? {24'd0, init_byte(16'h0000)} : 32'h55);
    do_req(1'b0, 1'b1, 16'hFFFF, 16'h0000, lat, rd, flt);
    chk("wrap_rd_latency", lat, WRAP_EN ? 1 : 4);
    chk("wrap_rd_rdata", {16'd0, rd}, WRAP_EN ? 32'h0 : 32'h55AA);

    // Reset during WR_HI of a word write to 16'h3000.
    keep = ram[16'h3001];
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_word = 1'b1; req_addr = 16'h3000; req_wdata = 16'hC3D4;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("wrhi_we_before_rst", {31'd0, mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_forces_we_low", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mid_ram_3001", {24'd0, ram[16'h3001]}, {24'd0, keep});
    chk("rst_mid_ram_3000", {24'd0, ram[16'h3000]}, 32'hD4);
    ref_mem[16'h3000] = 8'hD4;

    // Handshake: three byte reads with req_valid held high.
    hq[0] = 16'h1234; hq[1] = 16'h2001; hq[2] = 16'h3001;
    idx = 0; pulses = 0;
    req_write = 1'b0; req_word = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        if (pulses < 3)
          chk($sformatf("hs_rdata%0d", pulses), {16'd0, rsp_rdata}, {24'd0, ref_mem[hq[pulses]]});
        pulses++;
      end
      if (idx < 3) begin
        req_valid = 1'b1; req_addr = hq[idx];
      end else begin
        req_valid = 1'b0;
      end
      if (req_valid && req_ready) begin
        acc_cyc[idx] = c;
        idx++;
      end
    end
    req_valid = 1'b0;
    chk("hs_accepts", idx, 3);
    chk("hs_pulses", pulses, 3);
    if (idx == 3) begin
      chk("hs_gap01", acc_cyc[1] - acc_cyc[0], 4);
      chk("hs_gap12", acc_cyc[2] - acc_cyc[1], 4);
    end

    // Randomized accesses against the reference model.
    for (int n = 0; n < 150; n++) begin
      logic        wr, wd;
      logic [15:0] a, wdt, exp_rd;
      wr  = 1'($urandom_range(0, 1));
      wd  = 1'($urandom_range(0, 1));
      wdt = 16'($urandom);
      case ($urandom_range(0, 7))
        0: a = 16'hFFFF;
        1: a = 16'h0000;
        2: a = 16'hFFFE;
        default: a = 16'h4000 + 16'($urandom_range(0, 31));
      endcase
      do_req(wr, wd, a, wdt, lat, rd, flt);
      exp_rd = model_access(wr, wd, a, wdt);
      chk($sformatf("rnd%0d_latency", n), lat, exp_lat(wr, wd, a));
      chk($sformatf("rnd%0d_fault", n), {31'd0, flt}, {31'd0, is_fault(wd, a)});
      if (!wr) chk($sformatf("rnd%0d_rdata", n), {16'd0, rd}, {16'd0, exp_rd});
    end

    chk("we_oe_overlap", overlap_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
